// File: rtl/seven_seg_scan_mux_if.sv
// Bus between a display-value producer and the seven-segment scan multiplexer.
// Carries the value/load strobe and controls in, and the scan outputs back.
interface seven_seg_scan_mux_if #(
  parameter int N_DIGITS = 8
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [4*N_DIGITS-1:0] value_in;
  logic                  load;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  lz_suppress;
  logic [3:0]            bcd_out;
  logic [N_DIGITS-1:0]   AN;
  logic [IDX_W-1:0]      digit_idx;
  logic                  frame_done;

  modport master (
    output value_in, load, digit_en, lz_suppress,
    input  bcd_out, AN, digit_idx, frame_done
  );

  modport slave (
    input  value_in, load, digit_en, lz_suppress,
    output bcd_out, AN, digit_idx, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed scanner for a common-anode seven-segment display: blanking gap per
// slot, frame-boundary value updates (double-buffered) and optional leading-zero blanking.
module seven_seg_scan_mux #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seven_seg_scan_mux_if.slave  bus
);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int VAL_W = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDX_W-1:0]    idx_reg, idx_next;
  logic [VAL_W-1:0]    active_reg, active_next;
  logic [VAL_W-1:0]    shadow_reg, shadow_next;
  logic                pending_reg, pending_next;
  logic                frame_done_reg, frame_done_next;
  logic [N_DIGITS-1:0] an_reg, an_next;

  logic                slot_end;
  logic                boundary;
  logic [N_DIGITS-1:0] nz_next;
  logic [N_DIGITS-1:0] onehot_next;
  logic [IDX_W-1:0]    lead_idx;
  logic                visible_next;
  logic [3:0]          nibble [N_DIGITS];

  assign slot_end = (cnt_reg == CNT_LAST);
  assign boundary = slot_end && (idx_reg == IDX_LAST);

  always_comb begin
    cnt_next = slot_end ? '0 : cnt_reg + CNT_W'(1);
    idx_next = idx_reg;
    if (slot_end) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  // A load landing exactly on the boundary bypasses the shadow so it is not lost a frame.
  always_comb begin
    shadow_next     = shadow_reg;
    pending_next    = pending_reg;
    active_next     = active_reg;
    frame_done_next = boundary;
    if (bus.load) begin
      shadow_next  = bus.value_in;
      pending_next = 1'b1;
    end
    if (boundary) begin
      if (bus.load) begin
        active_next  = bus.value_in;
        pending_next = 1'b0;
      end else if (pending_reg) begin
        active_next  = shadow_reg;
        pending_next = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    assign nz_next[gi]     = |active_next[4*gi +: 4];
    assign onehot_next[gi] = (idx_next == IDX_W'(gi));
    assign nibble[gi]      = active_reg[4*gi +: 4];
  end

  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (nz_next[i]) begin
        lead_idx = IDX_W'(i);
      end
    end
  end

  // AN is registered from next-cycle state so no input reaches an output combinationally.
  always_comb begin
    visible_next = bus.digit_en[idx_next] &&
                   (!bus.lz_suppress || (idx_next <= lead_idx));
    an_next = '1;
    if ((cnt_next >= CNT_BLANK) && visible_next) begin
      an_next = ~onehot_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg        <= '0;
      idx_reg        <= '0;
      active_reg     <= '0;
      shadow_reg     <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      an_reg         <= '1;
    end else begin
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      active_reg     <= active_next;
      shadow_reg     <= shadow_next;
      pending_reg    <= pending_next;
      frame_done_reg <= frame_done_next;
      an_reg         <= an_next;
    end
  end

  assign bus.AN         = an_reg;
  assign bus.bcd_out    = nibble[idx_reg];
  assign bus.digit_idx  = idx_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Randomized bench for seven_seg_scan_mux against a cycle-count based behavioural model,
// plus literal checks of the directed scenarios.
module tb_seven_seg_scan_mux;
  localparam int N     = 8;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * RD;

  logic clk = 1'b0;
  logic reset;
  bit   check_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  seven_seg_scan_mux_if #(.N_DIGITS(N)) bus ();

  seven_seg_scan_mux #(
    .N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model: t counts cycles since reset; slot, position and digit follow by division.
  int unsigned t;
  logic [31:0] m_active, m_shadow;
  bit          m_pending, m_fd, m_lz;
  logic [7:0]  m_en;
  int unsigned cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    m_en <= bus.digit_en;
    m_lz <= bus.lz_suppress;
    if (reset) begin
      t <= 0; m_active <= 0; m_shadow <= 0; m_pending <= 0; m_fd <= 0;
    end else begin
      t    <= t + 1;
      m_fd <= ((t % FRAME) == FRAME - 1);
      if ((t % FRAME) == FRAME - 1) begin
        if (bus.load) begin
          m_active <= bus.value_in; m_shadow <= bus.value_in; m_pending <= 0;
        end else if (m_pending) begin
          m_active <= m_shadow; m_pending <= 0;
        end
      end else if (bus.load) begin
        m_shadow <= bus.value_in; m_pending <= 1;
      end
    end
  end

  function automatic logic [7:0] exp_an(int unsigned tt, logic [31:0] act, logic [7:0] en, bit lz);
    int idx, h;
    idx = (tt / RD) % N;
    h = 0;
    for (int i = 0; i < N; i++) if (((act >> (4 * i)) & 32'hF) != 0) h = i;
    if ((tt % RD) < BL) return 8'hFF;
    if (!en[idx]) return 8'hFF;
    if (lz && idx > h) return 8'hFF;
    return ~(8'h01 << idx);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("AN", {24'd0, bus.AN}, {24'd0, exp_an(t, m_active, m_en, m_lz)});
      chk("bcd_out", {28'd0, bus.bcd_out}, (m_active >> (4 * ((t / RD) % N))) & 32'hF);
      chk("digit_idx", {29'd0, bus.digit_idx}, (t / RD) % N);
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, m_fd});
    end
  end

  // Frame pulses must be exactly one frame apart, independent of enables.
  int last_fd = -1;
  always @(negedge clk) begin
    if (reset) last_fd = -1;
    else if (check_en && bus.frame_done) begin
      if (last_fd >= 0) chk("fd_spacing", cyc - last_fd, FRAME);
      last_fd = cyc;
    end
  end

  task automatic wait_t(input int pos);
    int n;
    n = 0;
    while ((t % FRAME) != pos && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_timeout: position %0d not reached", pos);
    end
  endtask

  task automatic do_load(input logic [31:0] v);
    bus.value_in = v;
    bus.load = 1'b1;
    $display("load 0x%08h at frame pos %0d", v, t % FRAME);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  function automatic logic [31:0] rand_value();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < N; i++)
      if ($urandom_range(2) == 0) v[4*i +: 4] = 4'($urandom_range(15));
    if ($urandom_range(3) == 0) v = v & 32'h0000_0FFF;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    bus.load = 1'b0; bus.value_in = 0; bus.digit_en = 8'hFF; bus.lz_suppress = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    chk("rst_AN", {24'd0, bus.AN}, 32'hFF);
    chk("rst_bcd", {28'd0, bus.bcd_out}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (130) @(negedge clk);

    // Load mid-frame becomes visible only after the boundary.
    wait_t(3 * RD + 1);
    do_load(32'h1234_5678);
    wait_t(4 * RD + 2);
    chk("t2_hold_bcd", {28'd0, bus.bcd_out}, 32'h0);
    wait_t(2);
    for (int k = 0; k < N; k++) begin
      wait_t(k * RD + 2);
      chk("t2_bcd", {28'd0, bus.bcd_out}, 8 - k);
      chk("t2_an", {24'd0, bus.AN}, {24'd0, ~(8'h01 << k)});
    end

    // Last load wins, and a boundary-cycle load bypasses the shadow.
    wait_t(10); do_load(32'h1111_1111);
    wait_t(30); do_load(32'hABCD_EF09);
    wait_t(FRAME - 1); do_load(32'h5555_5555);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) begin
        wait_t(k * RD + 3);
        chk("t3_bcd", {28'd0, bus.bcd_out}, 32'h5);
      end

    // Leading-zero suppression.
    bus.lz_suppress = 1'b1;
    wait_t(20); do_load(32'h0000_0305);
    wait_t(2);
    for (int k = 0; k < N; k++) begin
      wait_t(k * RD + 2);
      chk("t4_an", {24'd0, bus.AN}, (k <= 2) ? {24'd0, ~(8'h01 << k)} : 32'hFF);
    end
    wait_t(FRAME - 1); do_load(32'h0);
    for (int k = 0; k < N; k++) begin
      wait_t(k * RD + 4);
      chk("t4_zero_an", {24'd0, bus.AN}, (k == 0) ? 32'hFE : 32'hFF);
    end
    chk("t4_zero_bcd", {28'd0, bus.bcd_out}, 32'h0);

    // Digit enables: dark digits keep their slot.
    bus.lz_suppress = 1'b0;
    wait_t(20); do_load(32'h8765_4321);
    bus.digit_en = 8'h0F;
    wait_t(0);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) begin
        wait_t(k * RD + 5);
        chk("t5_an", {24'd0, bus.AN}, (k < 4) ? {24'd0, ~(8'h01 << k)} : 32'hFF);
      end

    // Randomized phase checked cycle by cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(49) == 0) bus.digit_en = 8'($urandom);
      if ($urandom_range(49) == 0) bus.lz_suppress = 1'($urandom);
      if ($urandom_range(499) == 0) begin
        reset = 1'b1; @(negedge clk); reset = 1'b0;
      end else if ($urandom_range(11) == 0) begin
        do_load(rand_value());
      end else begin
        @(negedge clk);
      end
    end

    // Reset during digit 5 discards the pending value.
    bus.digit_en = 8'hFF; bus.lz_suppress = 1'b0;
    wait_t(4 * RD + 1); do_load(32'hAAAA_BBBB);
    wait_t(5 * RD + 4);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_an", {24'd0, bus.AN}, 32'hFF);
    chk("t6_idx", {29'd0, bus.digit_idx}, 32'h0);
    chk("t6_bcd", {28'd0, bus.bcd_out}, 32'h0);
    reset = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < N; k++) begin
        wait_t(k * RD + 3);
        chk("t6_bcd_after", {28'd0, bus.bcd_out}, 32'h0);
      end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
